// File: rtl/imem_boot_loader.sv
// Boot loader that packs a length-prefixed byte stream into instruction-memory words and holds the core in reset until the load succeeds.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR-of-payload checksum byte.
module imem_boot_loader #(
  parameter int DLY        = 1,
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [RAM_WIDTH-1:0]  wr_data,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [3:0]            o_dbg_state
);

  // DLY is kept only for instantiation compatibility; registers update without delay.
  localparam int              BPW = RAM_WIDTH / 8 + 0 * DLY;
  localparam int              BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [16:0]     CAP = 17'd1 << ADDR_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_HI  = 4'd1,
    S_LEN_LO  = 4'd2,
    S_LEN_CHK = 4'd3,
    S_DATA    = 4'd4,
    S_WR_PREP = 4'd5,
    S_WR      = 4'd6,
    S_DONE    = 4'd7,
    S_ERR     = 4'd8
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM  = 4'd9
`endif
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  // Handshake: byte_data is consumed on a wr_clk edge where byte_valid && byte_ready.
  // byte_ready is registered from the FSM state, so a producer may hold byte_valid
  // for any number of cycles and gaps in byte_valid simply stall the loader.

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_acc;
  logic                   w_last_byte;
  logic                   w_last_word;
  logic [15:0]            r_len;
  logic [BCW-1:0]         r_bcnt;
  logic [RAM_WIDTH-1:0]   r_word;
  logic [RAM_WIDTH-1:0]   w_word_shift;
  logic                   w_byte_ready_nxt;
  logic                   w_wr_en_nxt;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;
  logic                   w_err_nxt;

  assign w_acc       = byte_valid & byte_ready;
  assign w_last_byte = (r_bcnt == BCW'(BPW - 1));
  assign w_last_word = (r_len == 16'd1);
  assign o_dbg_state = r_state;

  if (RAM_WIDTH > 8) begin : g_shift
    assign w_word_shift = {r_word[RAM_WIDTH-9:0], byte_data};
  end else begin : g_byte
    assign w_word_shift = byte_data;
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= 8'd0;
    end else if (start && (r_state inside {S_IDLE, S_DONE, S_ERR})) begin
      r_csum <= 8'd0;
    end else if (r_state == S_DATA && w_acc) begin
      r_csum <= r_csum ^ byte_data;
    end
  end
`endif

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_acc) w_state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_acc) w_state_nxt = S_LEN_CHK;
      end
      S_LEN_CHK: begin
        // An oversized image is rejected before any memory write happens.
        if (r_len == 16'd0)              w_state_nxt = S_TAIL;
        else if ({1'b0, r_len} > CAP)    w_state_nxt = S_ERR;
        else                             w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_acc && w_last_byte) w_state_nxt = S_WR_PREP;
      end
      S_WR_PREP: begin
        w_state_nxt = S_WR;
      end
      S_WR: begin
        w_state_nxt = w_last_word ? S_TAIL : S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_acc) w_state_nxt = (byte_data == r_csum) ? S_DONE : S_ERR;
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output values are decoded from the next state so they line up with it after the edge.
  always_comb begin
    w_byte_ready_nxt = 1'b0;
    w_wr_en_nxt      = 1'b0;
    w_done_nxt       = 1'b0;
    w_err_nxt        = 1'b0;
    w_busy_nxt       = !(w_state_nxt inside {S_IDLE, S_DONE, S_ERR});
    case (w_state_nxt)
      S_LEN_HI, S_LEN_LO, S_DATA: w_byte_ready_nxt = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:                     w_byte_ready_nxt = 1'b1;
`endif
      S_WR:                       w_wr_en_nxt      = 1'b1;
      S_DONE:                     w_done_nxt       = 1'b1;
      S_ERR:                      w_err_nxt        = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_rst_n  <= 1'b0;
    end else begin
      byte_ready <= w_byte_ready_nxt;
      wr_en      <= w_wr_en_nxt;
      busy       <= w_busy_nxt;
      done       <= w_done_nxt;
      err        <= w_err_nxt;
      cpu_rst_n  <= w_done_nxt;
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len   <= 16'd0;
      r_bcnt  <= '0;
      r_word  <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            wr_addr <= '0;
            r_bcnt  <= '0;
          end
        end
        S_LEN_HI: begin
          if (w_acc) r_len[15:8] <= byte_data;
        end
        S_LEN_LO: begin
          if (w_acc) r_len[7:0] <= byte_data;
        end
        S_DATA: begin
          if (w_acc) begin
            r_word <= w_word_shift;
            r_bcnt <= w_last_byte ? '0 : r_bcnt + 1'b1;
          end
        end
        S_WR_PREP: begin
          wr_data <= r_word;
        end
        S_WR: begin
          // r_len doubles as the remaining-word count; the last address is held.
          r_len <= r_len - 16'd1;
          if (!w_last_word) wr_addr <= wr_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
